// File: rtl/fetch_decode_regs.sv
// PC register plus IF/ID and ID/EX pipeline registers, with saturating stall/flush debug counters.
// Latency: one cycle per register; every output comes straight from a flop (or a fixed field of one).
// Backpressure: stall_pc_i holds PC, stall_id_i holds IF/ID; flush inputs insert all-zero bubbles.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   instr_i                          IMEM data for the current pc_o
//   stall_pc_i, stall_id_i           hazard-unit hold requests for PC and IF/ID
//   flush_ifid_i, flush_idex_i       hazard-unit bubble requests for IF/ID and ID/EX
//   pcsel_i/branch_target_i          taken branch resolved in ID
//   jump_i/jump_target_i             jump in ID (wins over a branch)
//   id_*_i                           decoded ID-stage fields loaded into ID/EX
//   pc_o, ifid_*_o, idex_*_o         register outputs
//   stall_cnt_o, flush_cnt_o         saturating debug counters
module fetch_decode_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_i,
    input  logic             stall_pc_i,
    input  logic             stall_id_i,
    input  logic             flush_ifid_i,
    input  logic             flush_idex_i,
    input  logic             pcsel_i,
    input  logic [31:0]      branch_target_i,
    input  logic             jump_i,
    input  logic [31:0]      jump_target_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             id_memwrite_i,
    input  logic [31:0]      id_rdata1_i,
    input  logic [31:0]      id_rdata2_i,
    input  logic [31:0]      id_imm_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_instr_o,
    output logic [4:0]       ifid_rs_o,
    output logic [4:0]       ifid_rt_o,
    output logic [31:0]      ifid_pc4_o,
    output logic [4:0]       idex_rs_o,
    output logic [4:0]       idex_rt_o,
    output logic [4:0]       idex_rd_o,
    output logic             idex_regwrite_o,
    output logic             idex_memread_o,
    output logic             idex_memwrite_o,
    output logic [31:0]      idex_rdata1_o,
    output logic [31:0]      idex_rdata2_o,
    output logic [31:0]      idex_imm_o,
    output logic [31:0]      idex_pc4_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_t;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [31:0] pc4;
    } idex_t;

    logic [31:0] pc_q, pc_d, pc_plus4;
    ifid_t       ifid_q, ifid_d;
    idex_t       idex_q, idex_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        // Stall dominates any redirect: a redirect computed from unresolved operands is bogus.
        pc_d = pc_plus4;
        if (stall_pc_i)   pc_d = pc_q;
        else if (jump_i)  pc_d = jump_target_i;
        else if (pcsel_i) pc_d = branch_target_i;
    end

    always_comb begin
        // Stall beats flush so a stalled branch/jump stays in ID; the flush lands on release.
        ifid_d = '{instr: instr_i, pc4: pc_plus4};
        if (stall_id_i)        ifid_d = ifid_q;
        else if (flush_ifid_i) ifid_d = '0;
    end

    always_comb begin
        // ID/EX is never held: a load-use stall is "hold IF/ID + bubble ID/EX".
        idex_d = '{rs:       ifid_q.instr[25:21],
                   rt:       ifid_q.instr[20:16],
                   rd:       id_rd_i,
                   regwrite: id_regwrite_i,
                   memread:  id_memread_i,
                   memwrite: id_memwrite_i,
                   rdata1:   id_rdata1_i,
                   rdata2:   id_rdata2_i,
                   imm:      id_imm_i,
                   pc4:      ifid_q.pc4};
        if (flush_idex_i) idex_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            ifid_q <= '0;
            idex_q <= '0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
            idex_q <= idex_d;
        end
    end

    // Debug counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_pc_i && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if ((flush_ifid_i || flush_idex_i) && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign pc_o            = pc_q;
    assign ifid_instr_o    = ifid_q.instr;
    assign ifid_rs_o       = ifid_q.instr[25:21];
    assign ifid_rt_o       = ifid_q.instr[20:16];
    assign ifid_pc4_o      = ifid_q.pc4;
    assign idex_rs_o       = idex_q.rs;
    assign idex_rt_o       = idex_q.rt;
    assign idex_rd_o       = idex_q.rd;
    assign idex_regwrite_o = idex_q.regwrite;
    assign idex_memread_o  = idex_q.memread;
    assign idex_memwrite_o = idex_q.memwrite;
    assign idex_rdata1_o   = idex_q.rdata1;
    assign idex_rdata2_o   = idex_q.rdata2;
    assign idex_imm_o      = idex_q.imm;
    assign idex_pc4_o      = idex_q.pc4;
    assign stall_cnt_o     = stall_cnt_q;
    assign flush_cnt_o     = flush_cnt_q;

endmodule
